fifo_prog: RTL
==============

Name: fifo_prog

Overview:
Parametrised synchronous FIFO, the next generation of the team's transaction-layer FIFO.
- Generalises word width and depth.
- Pointers carry an extra wrap bit, so the block distinguishes full from empty exactly.
- Almost-empty and almost-full thresholds are programmable at run time.
- Exposes live occupancy, a registered read port with a valid strobe, and sticky overflow/underflow errors.
- Sits between transaction-layer producers and consumers wherever backpressure thresholds must be tuned without re-synthesis.

Parameters:
DATA_WIDTH, 10, bits per stored word
FIFO_DEPTH, 8, number of entries; must be a power of 2, minimum 2
PTR_SIZE, $clog2(FIFO_DEPTH), address bits; internal pointers are PTR_SIZE+1 bits
CNT_SIZE, PTR_SIZE+1, width of occupancy and threshold ports

Ports:
clk  input  1  single clock; all state changes on the rising edge
reset_L  input  1  asynchronous active-low reset
data_in  input  DATA_WIDTH  write data
wr_en  input  1  push request
rd_en  input  1  pop request
ae_th  input  CNT_SIZE  almost-empty threshold; sampled every cycle
af_th  input  CNT_SIZE  almost-full threshold; sampled every cycle
err_clr  input  1  clears the sticky error flags
data_out  output  DATA_WIDTH  registered read data
data_valid  output  1  one-cycle strobe; data_out holds a newly popped word
count  output  CNT_SIZE  current occupancy, 0..FIFO_DEPTH
empty_flag  output  1  count == 0
full_flag  output  1  count == FIFO_DEPTH
almost_empty_flag  output  1  0 < count <= ae_th
almost_full_flag  output  1  af_th <= count < FIFO_DEPTH
overflow_flag  output  1  sticky; a push was rejected
underflow_flag  output  1  sticky; a pop was rejected

Behaviour:
- Reset (async, reset_L=0): pointers=0, count=0, data_out=0, data_valid=0, overflow_flag=0, underflow_flag=0.
  - Flags during reset: empty_flag=1, full_flag=0, almost_empty_flag=0, almost_full_flag=0.
  - Memory array is not reset; its contents are discarded.
  - Reset asserted mid-operation aborts any in-flight pop: data_valid=0 immediately.
- Pointers: wr_ptr and rd_ptr are PTR_SIZE+1 bits. Address is ptr[PTR_SIZE-1:0]; wrap is natural modulo 2*FIFO_DEPTH.
  - count = wr_ptr - rd_ptr, computed modulo 2^CNT_SIZE.
- Flag timing: all status flags and count are combinational decodes of the registered pointers. They reflect the state after the last clock edge, with no extra latency.
- Pop accept: pop_ok = rd_en && !empty_flag.
  - At the edge, data_out <= mem[rd_addr], rd_ptr++, data_valid <= 1.
  - If no pop is accepted: data_valid <= 0 and data_out holds its value.
  - Read latency is 1 cycle. There is no fall-through: a word written into an empty FIFO can be popped no earlier than the next cycle.
- Push accept: push_ok = wr_en && (!full_flag || pop_ok).
  - At the edge, mem[wr_addr] <= data_in and wr_ptr++.
- Simultaneous push and pop:
  - Full FIFO: both are accepted and count is unchanged.
  - Empty FIFO: the push is accepted and the pop is rejected (underflow).
  - Non-boundary: both are accepted and count is unchanged.
- Overflow: wr_en && !push_ok sets overflow_flag at the edge. The word is dropped; memory and pointers are unchanged.
- Underflow: rd_en && empty_flag sets underflow_flag at the edge. Pointers are unchanged and data_valid=0.
- Error flag clear: err_clr=1 clears both error flags at the edge. A new error event in the same cycle wins, and the flag stays 1.
- Thresholds are compared unsigned against count.
  - ae_th=0 disables almost_empty_flag.
  - af_th > FIFO_DEPTH-1 disables almost_full_flag.
  - Changing a threshold takes effect combinationally; no state is involved.
- Ordering is strictly FIFO across any number of pointer wraps.

Test Plan:
1. Reset, then push 8 words 0x001..0x008 with no pops -> after the 8th edge count=8, full_flag=1; almost_full_flag rises at count=6 (af_th=6) and drops at count=8; overflow_flag=0.
2. From full, push 0x3FF for 1 cycle -> overflow_flag=1, count stays 8; then pop 8 times -> data_out sequence 0x001..0x008, each with data_valid one cycle after the rd_en cycle; 0x3FF never appears.
3. From empty, assert rd_en and wr_en (data 0x155) together -> underflow_flag=1, count=1, data_valid=0; next cycle pop -> data_out=0x155, data_valid=1.
4. Fill to 8, then hold wr_en=rd_en=1 for 20 cycles with an incrementing data pattern -> full_flag stays 1, count=8, no overflow; pops return words in order across 2+ pointer wraps.
5. With ae_th=3, af_th=5, fill from 0 to 8 -> almost_empty_flag=1 for count 1..3, almost_full_flag=1 for count 5..7; change af_th to 7 at count=6 -> almost_full_flag drops the same cycle. Then assert err_clr together with a rejected push -> overflow_flag stays 1; err_clr alone on the next cycle -> overflow_flag=0.
6. Pop in progress at count=4 with reset_L pulsed low mid-cycle -> all outputs reach reset values without waiting for a clock edge; after release, empty_flag=1 and the first push/pop round-trips correctly.

Source files
------------

// File: rtl/fifo_prog.sv
// ---------------------------------------------------------------------------
// fifo_prog -- parametrised synchronous FIFO with programmable thresholds
//
// A single-clock FIFO for transaction-layer traffic. Pointers carry one extra
// wrap bit above the address so that "full" and "empty" are told apart
// exactly, without a separate occupancy counter. Almost-empty and almost-full
// thresholds are plain inputs and are compared combinationally, so they can
// be retuned at run time with no pipeline effect.
//
// The read port is registered. A popped word appears on data_out one cycle
// after the accepted rd_en, and data_valid strobes for that one cycle. There
// is no fall-through path: a word pushed into an empty FIFO becomes poppable
// on the following cycle.
//
// Overflow and underflow are sticky. They set on a rejected push or pop and
// clear on err_clr. A new error in the same cycle as err_clr keeps the flag
// set.
//
// Parameters
//   DATA_WIDTH  bits per stored word
//   FIFO_DEPTH  number of entries (power of 2, >= 2)
//   PTR_SIZE    address bits; the pointers are PTR_SIZE+1 bits wide
//   CNT_SIZE    width of count and of the threshold inputs
//
// Ports
//   clk                in   rising-edge clock
//   reset_L            in   asynchronous active-low reset
//   data_in            in   write data
//   wr_en              in   push request
//   rd_en              in   pop request
//   ae_th              in   almost-empty threshold (0 disables the flag)
//   af_th              in   almost-full threshold (> FIFO_DEPTH-1 disables)
//   err_clr            in   clears both sticky error flags
//   data_out           out  registered read data; holds between pops
//   data_valid         out  one-cycle strobe: data_out carries a new word
//   count              out  occupancy, 0..FIFO_DEPTH
//   empty_flag         out  count == 0
//   full_flag          out  count == FIFO_DEPTH
//   almost_empty_flag  out  0 < count <= ae_th
//   almost_full_flag   out  af_th <= count < FIFO_DEPTH
//   overflow_flag      out  sticky: a push was rejected
//   underflow_flag     out  sticky: a pop was rejected
// ---------------------------------------------------------------------------
module fifo_prog #(
  parameter int DATA_WIDTH = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_SIZE   = $clog2(FIFO_DEPTH),
  parameter int CNT_SIZE   = PTR_SIZE + 1
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [CNT_SIZE-1:0]   ae_th,
  input  logic [CNT_SIZE-1:0]   af_th,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [CNT_SIZE-1:0]   count,
  output logic                  empty_flag,
  output logic                  full_flag,
  output logic                  almost_empty_flag,
  output logic                  almost_full_flag,
  output logic                  overflow_flag,
  output logic                  underflow_flag
);

  // Depth expressed in the occupancy width, so every comparison against
  // count is between operands of equal width.
  localparam logic [CNT_SIZE-1:0] DEPTH_CNT = CNT_SIZE'(FIFO_DEPTH);
  localparam logic [PTR_SIZE:0]   PTR_ONE   = (PTR_SIZE+1)'(1);

  // -------------------------------------------------------------------------
  // Storage and pointers
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PTR_SIZE:0]   wr_ptr;
  logic [PTR_SIZE:0]   rd_ptr;
  logic [PTR_SIZE-1:0] wr_addr;
  logic [PTR_SIZE-1:0] rd_addr;

  logic pop_ok;
  logic push_ok;

  // The low bits address the array. The top bit flips on each pass through
  // the array, so equal addresses with different wrap bits mean "full".
  assign wr_addr = wr_ptr[PTR_SIZE-1:0];
  assign rd_addr = rd_ptr[PTR_SIZE-1:0];

  // -------------------------------------------------------------------------
  // Status decode -- purely combinational from the registered pointers.
  // -------------------------------------------------------------------------
  // NOTE: every output of an always_comb gets a default before any
  // conditional logic. A path that leaves a signal unassigned infers a latch.
  always_comb begin
    count             = '0;
    empty_flag        = 1'b0;
    full_flag         = 1'b0;
    almost_empty_flag = 1'b0;
    almost_full_flag  = 1'b0;

    // Pointer difference modulo 2^CNT_SIZE. The wrap bit makes this
    // unambiguous for every occupancy from 0 to FIFO_DEPTH.
    count      = CNT_SIZE'(wr_ptr - rd_ptr);
    empty_flag = (count == '0);
    full_flag  = (count == DEPTH_CNT);

    // ae_th == 0 can never satisfy "0 < count <= ae_th", so zero disables it.
    almost_empty_flag = (count != '0) && (count <= ae_th);

    // A threshold above FIFO_DEPTH-1 can never satisfy "af_th <= count <
    // FIFO_DEPTH", so a large value disables the flag.
    almost_full_flag  = (count >= af_th) && (count < DEPTH_CNT);
  end

  // A pop needs data in the FIFO. A push needs room. When the FIFO is full,
  // a pop accepted in the same cycle frees a slot, so both proceed and the
  // occupancy does not change. On an empty FIFO the pop is rejected while the
  // push goes in, which is the no-fall-through behaviour.
  assign pop_ok  = rd_en && !empty_flag;
  assign push_ok = wr_en && (!full_flag || pop_ok);

  // -------------------------------------------------------------------------
  // Pointer registers
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever the order of the always blocks.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Memory write
  // -------------------------------------------------------------------------
  // NOTE: the array has no reset. After reset the pointers say "empty", so
  // old contents are unreachable. A reset would also stop the array from
  // mapping onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_addr] <= data_in;
  end

  // -------------------------------------------------------------------------
  // Registered read port
  // -------------------------------------------------------------------------
  // data_out keeps the last popped word when nothing is popped. data_valid
  // marks only the cycle in which a fresh word appears. Because the reset is
  // asynchronous, a pop in flight is dropped as soon as reset_L falls.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (pop_ok) begin
      data_out   <= mem[rd_addr];
      data_valid <= 1'b1;
    end else begin
      data_valid <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky error flags
  // -------------------------------------------------------------------------
  // The set condition is checked before the clear, so an error in the same
  // cycle as err_clr wins and the flag stays set.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      overflow_flag  <= 1'b0;
      underflow_flag <= 1'b0;
    end else begin
      if (wr_en && !push_ok)    overflow_flag <= 1'b1;
      else if (err_clr)         overflow_flag <= 1'b0;

      if (rd_en && empty_flag)  underflow_flag <= 1'b1;
      else if (err_clr)         underflow_flag <= 1'b0;
    end
  end

endmodule
